fetch_stage: RTL and testbench

- Instruction-fetch stage of the 32-bit MIPS datapath. Holds the program counter and issues fetch requests to instruction memory. Loads the fetched word into the IF/ID pipeline register.
- PCOut drives the PC+4 Adder (A=PCOut, B=32'd4). The Adder's sum returns on PCPlus4 as the sequential next PC.
- Handles variable-latency instruction memory, hazard-unit stalls (with a one-entry hold buffer) and branch/jump redirects from EX.

---
 rtl/datapath_pkg.sv | 13 +
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 137 +++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the MIPS datapath: fetch FSM encodings and reset constants.
package datapath_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads from the fetch path or the hold buffer; flush marks a bubble.
module if_id_reg
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              sel_hold,
    input  logic              flush,
    input  logic [DATA_W-1:0] fetch_instr,
    input  logic [DATA_W-1:0] fetch_pcplus4,
    input  logic [DATA_W-1:0] hold_instr,
    input  logic [DATA_W-1:0] hold_pcplus4,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pcplus4,
    output logic              valid
);

    // Flush only clears valid; the stale word stays visible but is marked a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr   <= DATA_W'(INSTR_NOP);
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            instr   <= sel_hold ? hold_instr   : fetch_instr;
            pcplus4 <= sel_hold ? hold_pcplus4 : fetch_pcplus4;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM with one-entry hold buffer, redirect handling.
module fetch_stage
    import datapath_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [DATA_W-1:0] BranchTarget,
    input  logic              PCSrc,
    input  logic              Stall,
    input  logic              IMemReady,
    input  logic [DATA_W-1:0] IMemData,
    output logic [DATA_W-1:0] PCOut,
    output logic              IMemReq,
    output logic [DATA_W-1:0] IMemAddr,
    output logic [DATA_W-1:0] IF_ID_Instr,
    output logic [DATA_W-1:0] IF_ID_PCPlus4,
    output logic              IF_ID_Valid
);

    fetch_state_t      state, next_state;
    logic [DATA_W-1:0] pc, pc_d;
    logic              pc_load;
    logic [DATA_W-1:0] hold_instr, hold_pcplus4;
    logic              hold_full, hold_capture, hold_clear;
    logic              ifid_load, ifid_sel_hold, ifid_flush;
    logic [DATA_W-1:0] redirect_pc;

    assign redirect_pc = BranchTarget & ~{{(DATA_W-2){1'b0}}, 2'b11};
    assign PCOut       = pc;
    assign IMemAddr    = pc;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            if (pc_load) pc <= pc_d;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hold_full    <= 1'b0;
            hold_instr   <= '0;
            hold_pcplus4 <= '0;
        end else if (hold_clear) begin
            hold_full <= 1'b0;
        end else if (hold_capture) begin
            hold_full    <= 1'b1;
            hold_instr   <= IMemData;
            hold_pcplus4 <= PCPlus4;
        end
    end

    // Redirect outranks stall and memory response in every state that fetches.
    always_comb begin
        next_state    = state;
        IMemReq       = 1'b0;
        pc_load       = 1'b0;
        pc_d          = PCPlus4;
        hold_capture  = 1'b0;
        hold_clear    = 1'b0;
        ifid_load     = 1'b0;
        ifid_sel_hold = 1'b0;
        ifid_flush    = 1'b0;
        unique case (state)
            BOOT: begin
                next_state = FETCH;
                if (PCSrc) begin
                    pc_load = 1'b1;
                    pc_d    = redirect_pc;
                end
            end
            FETCH: begin
                IMemReq = 1'b1;
                if (PCSrc) begin
                    pc_load    = 1'b1;
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                    hold_clear = 1'b1;
                end else if (IMemReady && !Stall) begin
                    ifid_load = 1'b1;
                    pc_load   = 1'b1;
                end else if (IMemReady && Stall) begin
                    hold_capture = 1'b1;
                    next_state   = HELD;
                end else if (!IMemReady && !Stall) begin
                    ifid_flush = 1'b1;
                end
            end
            HELD: begin
                if (PCSrc) begin
                    pc_load    = 1'b1;
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                    hold_clear = 1'b1;
                    next_state = FETCH;
                end else if (!Stall) begin
                    ifid_load     = hold_full;
                    ifid_sel_hold = 1'b1;
                    pc_load       = 1'b1;
                    hold_clear    = 1'b1;
                    next_state    = FETCH;
                end
            end
            default: next_state = BOOT;
        endcase
    end

    if_id_reg #(.DATA_W(DATA_W)) u_if_id (
        .clk          (Clk),
        .rst          (Rst),
        .load         (ifid_load),
        .sel_hold     (ifid_sel_hold),
        .flush        (ifid_flush),
        .fetch_instr  (IMemData),
        .fetch_pcplus4(PCPlus4),
        .hold_instr   (hold_instr),
        .hold_pcplus4 (hold_pcplus4),
        .instr        (IF_ID_Instr),
        .pcplus4      (IF_ID_PCPlus4),
        .valid        (IF_ID_Valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with an external PC+4 adder and a simple memory model.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] PCPlus4, BranchTarget, IMemData;
    logic        PCSrc, Stall, IMemReady;
    logic [31:0] PCOut, IMemAddr, IF_ID_Instr, IF_ID_PCPlus4;
    logic        IMemReq, IF_ID_Valid;

    logic        use_rom;
    logic [31:0] mem_word;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 Clk = ~Clk;

    assign PCPlus4  = PCOut + 32'd4;
    assign IMemData = use_rom ? (32'hA000_0000 | IMemAddr) : mem_word;

    fetch_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .PCPlus4      (PCPlus4),
        .BranchTarget (BranchTarget),
        .PCSrc        (PCSrc),
        .Stall        (Stall),
        .IMemReady    (IMemReady),
        .IMemData     (IMemData),
        .PCOut        (PCOut),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid  (IF_ID_Valid)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pcp4, input logic valid);
        check_vec({tag, ".instr"}, IF_ID_Instr, instr);
        check_vec({tag, ".pcp4"},  IF_ID_PCPlus4, pcp4);
        check_vec({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, valid});
    endtask

    task automatic check_pc(input string tag, input logic [31:0] pc, input logic req);
        check_vec({tag, ".pc"},   PCOut, pc);
        check_vec({tag, ".addr"}, IMemAddr, pc);
        check_vec({tag, ".req"},  {31'd0, IMemReq}, {31'd0, req});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b1; PCSrc = 1'b0; Stall = 1'b0; IMemReady = 1'b1;
        BranchTarget = 32'h0; use_rom = 1'b1; mem_word = 32'h0;
        tick(); tick();
        check_pc("reset", 32'h0, 1'b0);
        check_ifid("reset", 32'h0, 32'h0, 1'b0);
        Rst = 1'b0;

        // zero-wait streaming
        tick(); check_pc("boot", 32'h0, 1'b1); check_ifid("boot", 32'h0, 32'h0, 1'b0);
        tick(); check_pc("zw1", 32'h4, 1'b1);  check_ifid("zw1", 32'hA000_0000, 32'h4, 1'b1);
        tick(); check_pc("zw2", 32'h8, 1'b1);  check_ifid("zw2", 32'hA000_0004, 32'h8, 1'b1);
        tick(); check_pc("zw3", 32'hC, 1'b1);  check_ifid("zw3", 32'hA000_0008, 32'hC, 1'b1);
        tick(); check_pc("zw4", 32'h10, 1'b1); check_ifid("zw4", 32'hA000_000C, 32'h10, 1'b1);

        // two wait states at PC 0x10
        IMemReady = 1'b0;
        tick(); check_pc("ws1", 32'h10, 1'b1); check_ifid("ws1", 32'hA000_000C, 32'h10, 1'b0);
        tick(); check_pc("ws2", 32'h10, 1'b1); check_ifid("ws2", 32'hA000_000C, 32'h10, 1'b0);
        IMemReady = 1'b1; use_rom = 1'b0; mem_word = 32'h8C01_0004;
        tick(); check_pc("ws3", 32'h14, 1'b1); check_ifid("ws3", 32'h8C01_0004, 32'h14, 1'b1);

        // not ready while stalled: everything holds
        IMemReady = 1'b0; Stall = 1'b1;
        tick(); check_pc("nrst", 32'h14, 1'b1); check_ifid("nrst", 32'h8C01_0004, 32'h14, 1'b1);

        // plain redirect to 0x20
        IMemReady = 1'b1; Stall = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h20; mem_word = 32'hBAD0_BAD0;
        tick(); check_pc("rd20", 32'h20, 1'b1); check_ifid("rd20", 32'h8C01_0004, 32'h14, 1'b0);

        // stall with ready: capture into hold buffer, 3 stall cycles
        PCSrc = 1'b0; Stall = 1'b1; mem_word = 32'h0022_1820;
        tick(); check_pc("st1", 32'h20, 1'b0); check_ifid("st1", 32'h8C01_0004, 32'h14, 1'b0);
        mem_word = 32'hBAD0_BAD0;
        tick(); check_pc("st2", 32'h20, 1'b0); check_ifid("st2", 32'h8C01_0004, 32'h14, 1'b0);
        tick(); check_pc("st3", 32'h20, 1'b0); check_ifid("st3", 32'h8C01_0004, 32'h14, 1'b0);
        Stall = 1'b0;
        tick(); check_pc("rel", 32'h24, 1'b1); check_ifid("rel", 32'h0022_1820, 32'h24, 1'b1);

        // redirect beats stall and ready; target alignment
        Stall = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h0000_0103; mem_word = 32'hDEAD_BEEF;
        tick(); check_pc("rdst", 32'h100, 1'b1); check_ifid("rdst", 32'h0022_1820, 32'h24, 1'b0);
        PCSrc = 1'b0; Stall = 1'b0; mem_word = 32'h1111_1111;
        tick(); check_pc("rdnx", 32'h104, 1'b1); check_ifid("rdnx", 32'h1111_1111, 32'h104, 1'b1);

        // redirect out of HELD, then wrap-around
        Stall = 1'b1; mem_word = 32'h2222_2222;
        tick(); check_pc("hd", 32'h104, 1'b0);
        PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        tick(); check_pc("hdrd", 32'hFFFF_FFFC, 1'b1); check_ifid("hdrd", 32'h1111_1111, 32'h104, 1'b0);
        PCSrc = 1'b0; Stall = 1'b0; mem_word = 32'h3333_3333;
        tick(); check_pc("wrap", 32'h0, 1'b1); check_ifid("wrap", 32'h3333_3333, 32'h0, 1'b1);

        // async reset mid-HELD
        Stall = 1'b1; mem_word = 32'h4444_4444;
        tick(); check_pc("hd2", 32'h0, 1'b0);
        #3 Rst = 1'b1;
        #1 check_pc("arst", 32'h0, 1'b0); check_ifid("arst", 32'h0, 32'h0, 1'b0);
        tick();
        Rst = 1'b0; Stall = 1'b0; use_rom = 1'b1;
        tick(); check_pc("rb1", 32'h0, 1'b1); check_ifid("rb1", 32'h0, 32'h0, 1'b0);
        tick(); check_pc("rb2", 32'h4, 1'b1); check_ifid("rb2", 32'hA000_0000, 32'h4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
